// File: rtl/hazard_sequencer_if.sv
// Pipeline-side bundle of the hazard sequencer: stage register fields in,
// per-stage write/flush/hold controls and forwarding selects out.
interface hazard_sequencer_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic       ex_memread;
  logic [4:0] ex_dest;
  logic       ex_regwrite;
  logic [4:0] mem_dest;
  logic       mem_regwrite;
  logic [4:0] wb_dest;
  logic       wb_regwrite;
  logic       mem_pcsrc;
  logic       dmem_req;
  logic       dmem_ready;
  logic       halt_req;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       pipe_hold;
  logic [1:0] forward_a;
  logic [1:0] forward_b;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread,
    output ex_dest, ex_regwrite, mem_dest, mem_regwrite,
    output wb_dest, wb_regwrite, mem_pcsrc, dmem_req, dmem_ready,
    output halt_req,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush,
    input  ex_mem_flush, pipe_hold, forward_a, forward_b
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread,
    input  ex_dest, ex_regwrite, mem_dest, mem_regwrite,
    input  wb_dest, wb_regwrite, mem_pcsrc, dmem_req, dmem_ready,
    input  halt_req,
    output pc_write, if_id_write, if_id_flush, id_ex_flush,
    output ex_mem_flush, pipe_hold, forward_a, forward_b
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Five-stage hazard/sequencing controller with drain-and-halt.
// HAZARD_FORWARD_EN adds the EX forwarding unit; otherwise RAW hazards stall.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_sequencer_if.slave      pipe,
  output logic                   halted,
  output logic                   error,
  output logic [2:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [1:0]        drain_cnt, drain_nxt;
  logic              mem_stall, load_use, hazard;
  logic              pc_w, ifid_w, ifid_f, idex_f, exmem_f, hold;
  logic [1:0]        fwd_a, fwd_b;

  function automatic logic hits(
    input logic [4:0] dst,
    input logic       we,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return we && dst != 5'd0 &&
           (dst == rs || (uses_rt && dst == rt));
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] mdst,
    input logic       mwe,
    input logic [4:0] wdst,
    input logic       wwe
  );
    if (src == 5'd0)              return 2'b00;
    if (mwe && mdst == src)       return 2'b10;
    if (wwe && wdst == src)       return 2'b01;
    return 2'b00;
  endfunction

  assign mem_stall = pipe.dmem_req && !pipe.dmem_ready;
  assign load_use  = hits(pipe.ex_rt, pipe.ex_memread,
                          pipe.id_rs, pipe.id_rt, pipe.id_uses_rt);

`ifdef HAZARD_FORWARD_EN
  assign hazard = load_use;
  assign fwd_a  = fwd_sel(pipe.ex_rs, pipe.mem_dest, pipe.mem_regwrite,
                          pipe.wb_dest, pipe.wb_regwrite);
  assign fwd_b  = fwd_sel(pipe.ex_rt, pipe.mem_dest, pipe.mem_regwrite,
                          pipe.wb_dest, pipe.wb_regwrite);
`else
  // Without forwarding any in-flight writer of a decode source must stall.
  assign hazard = load_use ||
    hits(pipe.ex_dest, pipe.ex_regwrite,
         pipe.id_rs, pipe.id_rt, pipe.id_uses_rt) ||
    hits(pipe.mem_dest, pipe.mem_regwrite,
         pipe.id_rs, pipe.id_rt, pipe.id_uses_rt) ||
    hits(pipe.wb_dest, pipe.wb_regwrite,
         pipe.id_rs, pipe.id_rt, pipe.id_uses_rt);
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      cur       <= nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    nxt       = cur;
    wait_nxt  = wait_cnt;
    drain_nxt = drain_cnt;
    pc_w      = 1'b0;
    ifid_w    = 1'b0;
    ifid_f    = 1'b0;
    idex_f    = 1'b0;
    exmem_f   = 1'b0;
    hold      = 1'b0;
    unique case (cur)
      RUN: begin
        wait_nxt = '0;
        if (mem_stall) begin
          hold     = 1'b1;
          wait_nxt = WAIT_W'(1);
          nxt      = MEM_WAIT;
        end else if (pipe.mem_pcsrc) begin
          pc_w    = 1'b1;
          ifid_w  = 1'b1;
          ifid_f  = 1'b1;
          idex_f  = 1'b1;
          exmem_f = 1'b1;
        end else if (pipe.halt_req) begin
          ifid_w    = 1'b1;
          ifid_f    = 1'b1;
          drain_nxt = 2'd3;
          nxt       = DRAIN;
        end else if (hazard) begin
          idex_f = 1'b1;
        end else begin
          pc_w   = 1'b1;
          ifid_w = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (pipe.dmem_ready) begin
          pc_w     = 1'b1;
          ifid_w   = 1'b1;
          wait_nxt = '0;
          nxt      = RUN;
        end else begin
          hold = 1'b1;
          if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
            nxt = ERROR;
          else
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      DRAIN: begin
        ifid_f = 1'b1;
        if (mem_stall) begin
          hold = 1'b1;
        end else begin
          ifid_w = 1'b1;
          // A late branch still steers the PC so we halt on its target.
          if (pipe.mem_pcsrc) begin
            pc_w    = 1'b1;
            idex_f  = 1'b1;
            exmem_f = 1'b1;
          end
          if (drain_cnt == 2'd0)
            nxt = HALTED;
          else
            drain_nxt = drain_cnt - 2'd1;
        end
      end
      HALTED: begin
        ifid_f = 1'b1;
        if (!pipe.halt_req)
          nxt = RUN;
      end
      ERROR: begin
        hold = 1'b1;
      end
      default: begin
        nxt = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (!pc_w && (cur == RUN || cur == MEM_WAIT || cur == DRAIN)
             && stall_count != '1)
      stall_count <= stall_count + STALL_CNT_W'(1);
  end

  assign pipe.pc_write     = rst_n & pc_w;
  assign pipe.if_id_write  = rst_n & ifid_w;
  assign pipe.if_id_flush  = !rst_n | ifid_f;
  assign pipe.id_ex_flush  = !rst_n | idex_f;
  assign pipe.ex_mem_flush = !rst_n | exmem_f;
  assign pipe.pipe_hold    = rst_n & hold;
  assign pipe.forward_a    = rst_n ? fwd_a : 2'b00;
  assign pipe.forward_b    = rst_n ? fwd_b : 2'b00;

  assign state  = cur;
  assign halted = (cur == HALTED);
  assign error  = (cur == ERROR);
endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized + directed bench for hazard_sequencer against a
// cycle-level behavioural model of the sequencing rules.
module tb_hazard_sequencer;
  localparam int TMO = 15;

  logic        clk;
  logic        rst_n;
  logic        halted;
  logic        error;
  logic [2:0]  state;
  logic [15:0] stall_count;

  hazard_sequencer_if pipe ();

  hazard_sequencer #(
    .MEM_TIMEOUT (TMO),
    .STALL_CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe        (pipe),
    .halted      (halted),
    .error       (error),
    .state       (state),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode in spec encoding, low-ready streak, DRAIN cycles left
  int m_state, m_lows, m_drain, m_stalls;
  int n_state, n_lows, n_drain;
  logic [5:0] e_ctl, e_msk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit need_stall();
    logic [4:0] srcs[$];
    srcs.push_back(pipe.id_rs);
    if (pipe.id_uses_rt) srcs.push_back(pipe.id_rt);
    foreach (srcs[i]) begin
      if (srcs[i] != 5'd0) begin
        if (pipe.ex_memread && pipe.ex_rt == srcs[i]) return 1'b1;
`ifndef HAZARD_FORWARD_EN
        if (pipe.ex_regwrite && pipe.ex_dest == srcs[i]) return 1'b1;
        if (pipe.mem_regwrite && pipe.mem_dest == srcs[i]) return 1'b1;
        if (pipe.wb_regwrite && pipe.wb_dest == srcs[i]) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
`ifdef HAZARD_FORWARD_EN
    if (pipe.mem_regwrite && pipe.mem_dest == src) return 2'b10;
    if (pipe.wb_regwrite && pipe.wb_dest == src) return 2'b01;
`endif
    return 2'b00;
  endfunction

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, hold}
  task automatic model_eval();
    bit wt;
    wt = pipe.dmem_req && !pipe.dmem_ready;
    n_state = m_state;
    n_lows  = m_lows;
    n_drain = m_drain;
    e_msk   = 6'b111111;
    e_ctl   = 6'b000000;
    case (m_state)
      0: begin
        if (wt) begin
          e_ctl = 6'b000001; n_state = 1; n_lows = 1;
        end else if (pipe.mem_pcsrc) begin
          e_ctl = 6'b101110; e_msk = 6'b101111;
        end else if (pipe.halt_req) begin
          e_ctl = 6'b001000; e_msk = 6'b101111;
          n_state = 2; n_drain = 4;
        end else if (need_stall()) begin
          e_ctl = 6'b000100;
        end else begin
          e_ctl = 6'b110000;
        end
      end
      1: begin
        if (pipe.dmem_ready) begin
          e_ctl = 6'b110000; n_state = 0;
        end else begin
          e_ctl = 6'b000001;
          n_lows = m_lows + 1;
          if (n_lows >= TMO) n_state = 4;
        end
      end
      2: begin
        e_msk = 6'b101111;
        if (wt) begin
          e_ctl = 6'b001001;
        end else begin
          e_ctl = pipe.mem_pcsrc ? 6'b101110 : 6'b001000;
          n_drain = m_drain - 1;
          if (n_drain == 0) n_state = 3;
        end
      end
      3: begin
        e_ctl = 6'b001000; e_msk = 6'b101000;
        if (!pipe.halt_req) n_state = 0;
      end
      default: begin
        e_ctl = 6'b000001; e_msk = 6'b100001;
      end
    endcase
  endtask

  task automatic model_reset();
    m_state = 0; m_lows = 0; m_drain = 0; m_stalls = 0;
  endtask

  // Call at posedge+1 with inputs set; returns at next posedge+1.
  task automatic cycle();
    logic [5:0] got;
    model_eval();
    @(negedge clk);
    check("state", 32'(state), 32'(m_state));
    check("stalls", 32'(stall_count), 32'(m_stalls));
    check("halted", 32'(halted), 32'(m_state == 3));
    check("error", 32'(error), 32'(m_state == 4));
    got = {pipe.pc_write, pipe.if_id_write, pipe.if_id_flush,
           pipe.id_ex_flush, pipe.ex_mem_flush, pipe.pipe_hold};
    check("ctl", 32'(got & e_msk), 32'(e_ctl & e_msk));
    check("fwd_a", 32'(pipe.forward_a), 32'(exp_fwd(pipe.ex_rs)));
    check("fwd_b", 32'(pipe.forward_b), 32'(exp_fwd(pipe.ex_rt)));
    @(posedge clk);
    if (m_state <= 2 && !e_ctl[5] && m_stalls < 65535) m_stalls++;
    m_state = n_state; m_lows = n_lows; m_drain = n_drain;
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, 32'({pipe.pc_write, pipe.if_id_write,
                              pipe.if_id_flush, pipe.id_ex_flush,
                              pipe.ex_mem_flush, pipe.pipe_hold}),
          32'(6'b001110));
    check({tag, "_fwd"}, 32'({pipe.forward_a, pipe.forward_b}), 32'(0));
    check({tag, "_state"}, 32'(state), 32'(0));
    check({tag, "_stalls"}, 32'(stall_count), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_inputs();
    pipe.id_rs = 5'd0; pipe.id_rt = 5'd0; pipe.id_uses_rt = 1'b0;
    pipe.ex_rs = 5'd0; pipe.ex_rt = 5'd0; pipe.ex_memread = 1'b0;
    pipe.ex_dest = 5'd0; pipe.ex_regwrite = 1'b0;
    pipe.mem_dest = 5'd0; pipe.mem_regwrite = 1'b0;
    pipe.wb_dest = 5'd0; pipe.wb_regwrite = 1'b0;
    pipe.mem_pcsrc = 1'b0; pipe.dmem_req = 1'b0;
    pipe.dmem_ready = 1'b1; pipe.halt_req = 1'b0;
  endtask

  task automatic rand_inputs();
    pipe.id_rs = 5'($urandom_range(0, 3));
    pipe.id_rt = 5'($urandom_range(0, 3));
    pipe.id_uses_rt = 1'($urandom_range(0, 1));
    pipe.ex_rs = 5'($urandom_range(0, 3));
    pipe.ex_rt = 5'($urandom_range(0, 3));
    pipe.ex_memread = ($urandom_range(0, 2) == 0);
    pipe.ex_dest = 5'($urandom_range(0, 3));
    pipe.ex_regwrite = 1'($urandom_range(0, 1));
    pipe.mem_dest = 5'($urandom_range(0, 3));
    pipe.mem_regwrite = 1'($urandom_range(0, 1));
    pipe.wb_dest = 5'($urandom_range(0, 3));
    pipe.wb_regwrite = 1'($urandom_range(0, 1));
    pipe.mem_pcsrc = ($urandom_range(0, 7) == 0);
    pipe.dmem_req = ($urandom_range(0, 3) == 0);
    pipe.dmem_ready = ($urandom_range(0, 2) != 0);
    if ($urandom_range(0, 15) == 0) pipe.halt_req = !pipe.halt_req;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check_reset_outs("por");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // load-use on rs: one stall cycle, then the load has moved on
    pipe.ex_memread = 1'b1; pipe.ex_rt = 5'd5; pipe.id_rs = 5'd5;
    cycle();
    check("lu_stall_count", 32'(stall_count), 32'(1));
    idle_inputs();
    pipe.id_rs = 5'd5; pipe.mem_dest = 5'd5; pipe.mem_regwrite = 1'b1;
    cycle();

    // forwarding priority and $0
    idle_inputs();
    pipe.mem_dest = 5'd3; pipe.mem_regwrite = 1'b1;
    pipe.wb_dest = 5'd3; pipe.wb_regwrite = 1'b1; pipe.ex_rs = 5'd3;
    cycle();
    pipe.mem_regwrite = 1'b0;
    cycle();
    pipe.ex_rs = 5'd0; pipe.mem_dest = 5'd0; pipe.mem_regwrite = 1'b1;
    cycle();

    // branch wins over load-use
    idle_inputs();
    pipe.mem_pcsrc = 1'b1;
    pipe.ex_memread = 1'b1; pipe.ex_rt = 5'd7; pipe.id_rs = 5'd7;
    cycle();

    // three low cycles of ready
    idle_inputs();
    pipe.dmem_req = 1'b1; pipe.dmem_ready = 1'b0;
    repeat (3) cycle();
    pipe.dmem_ready = 1'b1;
    cycle();
    pipe.dmem_req = 1'b0;
    cycle();
    check("mw_back_run", 32'(state), 32'(0));

    // 14 lows: no timeout
    pipe.dmem_req = 1'b1; pipe.dmem_ready = 1'b0;
    repeat (TMO - 1) cycle();
    pipe.dmem_ready = 1'b1;
    cycle();
    check("tmo_edge_ok", 32'(error), 32'(0));

    // 15 lows: sticky error
    pipe.dmem_ready = 1'b0;
    repeat (TMO) cycle();
    pipe.dmem_ready = 1'b1; pipe.dmem_req = 1'b0;
    repeat (2) cycle();
    check("tmo_error", 32'({error, state}), 32'(4'b1100));
    do_reset();

    // drain and halt, then resume
    idle_inputs();
    pipe.halt_req = 1'b1;
    repeat (7) cycle();
    check("halted", 32'(halted), 32'(1));
    pipe.halt_req = 1'b0;
    repeat (2) cycle();

    // async reset mid-DRAIN
    pipe.halt_req = 1'b1;
    repeat (2) cycle();
    check("pre_rst_drain", 32'(state), 32'(2));
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs("async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
      if (m_state == 4) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
